// File: rtl/seven_segment_scanner.sv
// Multiplexed common-anode hex display driver, frame-synchronous data snapshot.
// Optional leading-zero suppression when LEADING_ZERO_BLANK_EN is defined.
module seven_segment_scanner #(
    parameter int DIGITS       = 8,
    parameter int BLANK_CYCLES = 16
) (
    input  logic                  InputCLK,
    input  logic                  nReset,
    input  logic                  ScanCLK,
    input  logic [4*DIGITS-1:0]   Data,
    input  logic [DIGITS-1:0]     DotMask,
    output logic [DIGITS-1:0]     Anodes,
    output logic [6:0]            Segments,
    output logic                  DP
);

    localparam int IW = (DIGITS > 2) ? $clog2(DIGITS) : 1;

    typedef enum logic [1:0] {IDLE, BLANK, DRIVE} state_t;

    state_t              state, stateNext;
    logic [2:0]          scanSync;
    logic                tick;
    logic [IW-1:0]       digitIdx, idxInc;
    logic                wrap, loadSnap;
    logic [7:0]          blankCnt;
    logic [4*DIGITS-1:0] snapData;
    logic [DIGITS-1:0]   snapDot;
    logic [3:0]          curNibble;
    logic [DIGITS-1:0]   anodesNext;
    logic [6:0]          segNext;
    logic                dpNext;

    function automatic logic [6:0] hexDecode(input logic [3:0] n);
        logic [6:0] s;
        unique case (n)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            4'hF: s = 7'h0E;
        endcase
        return s;
    endfunction

    // ScanCLK is asynchronous data: two sync flops plus an edge-history flop
    always_ff @(posedge InputCLK or negedge nReset) begin
        if (!nReset) scanSync <= '0;
        else         scanSync <= {scanSync[1:0], ScanCLK};
    end

    assign tick     = scanSync[1] & ~scanSync[2];
    assign wrap     = (digitIdx == IW'(DIGITS - 1));
    assign idxInc   = wrap ? '0 : digitIdx + 1'b1;
    assign loadSnap = tick & ((state == IDLE) | wrap);

    always_ff @(posedge InputCLK or negedge nReset) begin
        if (!nReset) state <= IDLE;
        else         state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        unique case (state)
            IDLE:  if (tick) stateNext = BLANK;
            BLANK: begin
                if (tick)
                    stateNext = BLANK;
                else if (blankCnt == 8'(BLANK_CYCLES - 1))
                    stateNext = DRIVE;
            end
            DRIVE: if (tick) stateNext = BLANK;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge InputCLK or negedge nReset) begin
        if (!nReset) begin
            digitIdx <= '0;
            blankCnt <= '0;
            snapData <= '0;
            snapDot  <= '0;
        end else begin
            if (tick) begin
                blankCnt <= '0;
                digitIdx <= (state == IDLE) ? '0 : idxInc;
            end else if (state == BLANK) begin
                blankCnt <= blankCnt + 8'd1;
            end
            if (loadSnap) begin
                snapData <= Data;
                snapDot  <= DotMask;
            end
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    logic [DIGITS-1:0] lzMask, blankMask;
    logic              lead;

    // Walk down from the top digit; digit 0 always stays visible
    always_comb begin
        lzMask = '0;
        lead   = 1'b1;
        for (int i = DIGITS - 1; i > 0; i--) begin
            if (lead && (Data[4*i +: 4] == 4'h0) && !DotMask[i])
                lzMask[i] = 1'b1;
            else
                lead = 1'b0;
        end
    end

    always_ff @(posedge InputCLK or negedge nReset) begin
        if (!nReset)       blankMask <= '0;
        else if (loadSnap) blankMask <= lzMask;
    end
`endif

    assign curNibble = snapData[{digitIdx, 2'b00} +: 4];

    always_comb begin
        anodesNext = '1;
        segNext    = 7'h7F;
        dpNext     = 1'b1;
        if (stateNext == DRIVE) begin
            anodesNext[digitIdx] = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
            if (!blankMask[digitIdx]) begin
                segNext = hexDecode(curNibble);
                dpNext  = ~snapDot[digitIdx];
            end
`else
            segNext = hexDecode(curNibble);
            dpNext  = ~snapDot[digitIdx];
`endif
        end
    end

    always_ff @(posedge InputCLK or negedge nReset) begin
        if (!nReset) begin
            Anodes   <= '1;
            Segments <= 7'h7F;
            DP       <= 1'b1;
        end else begin
            Anodes   <= anodesNext;
            Segments <= segNext;
            DP       <= dpNext;
        end
    end

endmodule

// File: tb/tb_seven_segment_scanner.sv
// Scoreboard bench for seven_segment_scanner (DIGITS=8, BLANK_CYCLES=16).
// Stimulus pushes cycle-stamped expectations; a negedge monitor checks them.
module tb_seven_segment_scanner;

    logic        InputCLK = 1'b0;
    logic        nReset;
    logic        ScanCLK;
    logic [31:0] Data;
    logic [7:0]  DotMask;
    logic [7:0]  Anodes;
    logic [6:0]  Segments;
    logic        DP;

    seven_segment_scanner #(.DIGITS(8), .BLANK_CYCLES(16)) dut (
        .InputCLK (InputCLK),
        .nReset   (nReset),
        .ScanCLK  (ScanCLK),
        .Data     (Data),
        .DotMask  (DotMask),
        .Anodes   (Anodes),
        .Segments (Segments),
        .DP       (DP)
    );

    always #5 InputCLK = ~InputCLK;

    int cyc = 0;
    always @(posedge InputCLK) cyc <= cyc + 1;

    typedef struct {
        int         at;
        logic [7:0] an;
        logic [6:0] seg;
        logic       dp;
        int         tag;
    } exp_t;

    exp_t q[$];
    int   nChecks = 0;
    int   nPass   = 0;

    logic [6:0] segTab [16] = '{7'h40, 7'h79, 7'h24, 7'h30,
                                7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h08, 7'h03,
                                7'h46, 7'h21, 7'h06, 7'h0E};

    int          mIdx  = 0;
    logic        mIdle = 1'b1;
    logic [31:0] mData = '0;
    logic [7:0]  mDot  = '0;
    logic [7:0]  mBlank = '0;

    function automatic void push(int at, logic [7:0] an, logic [6:0] seg,
                                 logic dp, int tag);
        exp_t e;
        e.at = at; e.an = an; e.seg = seg; e.dp = dp; e.tag = tag;
        q.push_back(e);
    endfunction

    function automatic void pushOff(int at, int tag);
        push(at, 8'hFF, 7'h7F, 1'b1, tag);
    endfunction

    function automatic void snap();
        logic lead;
        mData  = Data;
        mDot   = DotMask;
        mBlank = '0;
        lead   = 1'b1;
`ifdef LEADING_ZERO_BLANK_EN
        for (int i = 7; i > 0; i--) begin
            if (lead && mData[4*i +: 4] == 4'h0 && !mDot[i]) mBlank[i] = 1'b1;
            else lead = 1'b0;
        end
`endif
    endfunction

    always @(negedge InputCLK) begin : monitor
        exp_t e;
        while (q.size() > 0 && q[0].at <= cyc) begin
            e = q.pop_front();
            nChecks++;
            if (e.at != cyc || Anodes !== e.an || Segments !== e.seg || DP !== e.dp)
                $display("FAIL chk%0d cyc=%0d got an=%h seg=%h dp=%b want an=%h seg=%h dp=%b",
                         e.tag, cyc, Anodes, Segments, DP, e.an, e.seg, e.dp);
            else
                nPass++;
        end
    end

    // One ScanCLK period starting at a negedge; expectations derive from the model
    task automatic doTick(int period, int tag);
        int         n;
        logic [6:0] seg;
        logic       dp;
        @(negedge InputCLK);
        ScanCLK = 1'b1;
        n = cyc;
        if (mIdle) begin
            mIdle = 1'b0;
            mIdx  = 0;
            snap();
        end else begin
            mIdx = (mIdx + 1) % 8;
            if (mIdx == 0) snap();
        end
        seg = segTab[mData[4*mIdx +: 4]];
        dp  = ~mDot[mIdx];
        if (mBlank[mIdx]) begin
            seg = 7'h7F;
            dp  = 1'b1;
        end
        pushOff(n + 3, tag);
        if (period >= 20) begin
            pushOff(n + 18, tag);
            push(n + 19, ~(8'h01 << mIdx), seg, dp, tag);
            push(n + period - 1, ~(8'h01 << mIdx), seg, dp, tag);
        end else begin
            pushOff(n + period - 1, tag);
        end
        repeat (period / 2) @(negedge InputCLK);
        ScanCLK = 1'b0;
        repeat (period - period / 2 - 1) @(negedge InputCLK);
    endtask

    initial begin
        nReset  = 1'b0;
        ScanCLK = 1'b0;
        Data    = 32'h76543210;
        DotMask = 8'h00;
        pushOff(2, 1);
        pushOff(3, 1);
        repeat (4) @(negedge InputCLK);
        nReset = 1'b1;
        pushOff(cyc + 5, 2);
        pushOff(cyc + 40, 2);
        repeat (50) @(negedge InputCLK);

        for (int t = 0; t < 4; t++) doTick(1000, 10 + t);
        Data = 32'hFFFFFFFF;
        for (int t = 4; t < 9; t++) doTick(1000, 10 + t);

        Data    = 32'h89ABCDEF;
        DotMask = 8'h08;
        for (int t = 0; t < 10; t++) doTick(10, 30 + t);
        doTick(1000, 40);
        for (int t = 0; t < 7; t++) doTick(100, 41 + t);

        @(posedge InputCLK);
        #2 nReset = 1'b0;
        pushOff(cyc, 50);
        @(posedge InputCLK);
        #2 nReset = 1'b1;
        mIdle   = 1'b1;
        Data    = 32'h76543210;
        DotMask = 8'h01;
        pushOff(cyc + 10, 51);
        repeat (20) @(negedge InputCLK);
        doTick(1000, 52);

`ifdef LEADING_ZERO_BLANK_EN
        Data    = 32'h00000120;
        DotMask = 8'h00;
        for (int t = 0; t < 15; t++) doTick(100, 60 + t);
`endif

        repeat (5) @(negedge InputCLK);
        if (q.size() != 0) begin
            nChecks++;
            $display("FAIL pending got=%0d want=0", q.size());
        end
        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
